// File: rtl/i2c_pkg.sv
// Shared types for the register-oriented I2C master: FSM states, bit phases
// and response error codes.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    WR_BIT,
    WR_ACK,
    RSTART,
    RD_BIT,
    RD_ACK,
    STOP,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } phase_e;

  typedef enum logic [1:0] {
    I2C_OK        = 2'd0,
    I2C_NACK_ADDR = 2'd1,
    I2C_NACK_REG  = 2'd2,
    I2C_NACK_DATA = 2'd3
  } err_e;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      Q0:      return Q1;
      Q1:      return Q2;
      Q2:      return Q3;
      default: return Q0;
    endcase
  endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-period timer: divides clk into SCL quarters, tracks the bit phase and
// holds the start of Q1 while a slave stretches SCL low.
module i2c_quarter_timer
  import i2c_pkg::*;
#(
  parameter int unsigned QUARTER_CNT = 63
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   run_i,
  input  logic   scl_i,
  output phase_e phase_o,
  output logic   q_end_o
);

  localparam int unsigned CW = (QUARTER_CNT > 1) ? $clog2(QUARTER_CNT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  phase_e        phase_q, phase_d;
  logic          stall;

  always_comb begin
    stall   = (phase_q == Q1) && (cnt_q == '0) && !scl_i;
    q_end_o = run_i && !stall && (cnt_q == CW'(QUARTER_CNT - 1));
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!run_i) begin
      cnt_d   = '0;
      phase_d = Q0;
    end else if (q_end_o) begin
      cnt_d   = '0;
      phase_d = next_phase(phase_q);
    end else if (!stall) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= Q0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/i2c_master.sv
// Register-oriented I2C master: single-register write, and random read
// (addr+W, reg, Sr, addr+R, data, NACK) driving open-drain SCL/SDA enables.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned QUARTER_CNT = 63,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       busy,
  input  logic       scl_i,
  output logic       scl_oe,
  input  logic       sda_i,
  output logic       sda_oe
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_s, sda_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q[0] <= scl_i;
      sda_sync_q[0] <= sda_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  state_e     state_q, state_d;
  logic [1:0] byte_q, byte_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sr_q, sr_d;
  logic       ack_q, ack_d;
  logic       tail_q, tail_d;
  err_e       err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdata_q, wdata_d;
  logic       scl_oe_q, scl_oe_d;
  logic       sda_oe_q, sda_oe_d;

  phase_e     phase;
  logic       q_end;
  logic       run;
  logic       scl_low;
  logic       last_q3;
  logic [7:0] tx_byte;

  assign run = (state_q != IDLE) && (state_q != DONE);

  i2c_quarter_timer #(
    .QUARTER_CNT(QUARTER_CNT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run_i  (run),
    .scl_i  (scl_s),
    .phase_o(phase),
    .q_end_o(q_end)
  );

  always_comb begin
    case (byte_q)
      2'd0:    tx_byte = {dev_q, 1'b0};
      2'd1:    tx_byte = reg_q;
      default: tx_byte = rw_q ? {dev_q, 1'b1} : wdata_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    ack_d    = ack_q;
    tail_d   = tail_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    rw_d     = rw_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    scl_low  = (phase == Q0) || (phase == Q3);
    last_q3  = q_end && (phase == Q3);

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rw_d    = cmd_rw;
          dev_d   = cmd_dev_addr;
          reg_d   = cmd_reg_addr;
          wdata_d = cmd_wdata;
          err_d   = I2C_OK;
          byte_d  = 2'd0;
          tail_d  = 1'b0;
          state_d = START;
        end
      end
      START: begin
        sda_oe_d = (phase == Q2) || (phase == Q3);
        scl_oe_d = (phase == Q3);
        if (last_q3) begin
          bit_d   = 3'd7;
          state_d = WR_BIT;
        end
      end
      WR_BIT: begin
        scl_oe_d = scl_low;
        sda_oe_d = ~tx_byte[bit_q];
        if (last_q3) begin
          if (bit_q == 3'd0) state_d = WR_ACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      WR_ACK: begin
        scl_oe_d = scl_low;
        if (q_end && (phase == Q2)) ack_d = ~sda_s;
        if (last_q3) begin
          bit_d = 3'd7;
          if (!ack_q) begin
            // The repeated address byte (byte 2 of a read) reports as an address NACK.
            case (byte_q)
              2'd0:    err_d = I2C_NACK_ADDR;
              2'd1:    err_d = I2C_NACK_REG;
              default: err_d = rw_q ? I2C_NACK_ADDR : I2C_NACK_DATA;
            endcase
            state_d = STOP;
          end else if (byte_q == 2'd0) begin
            byte_d  = 2'd1;
            state_d = WR_BIT;
          end else if (byte_q == 2'd1) begin
            byte_d  = 2'd2;
            state_d = rw_q ? RSTART : WR_BIT;
          end else begin
            state_d = rw_q ? RD_BIT : STOP;
          end
        end
      end
      RSTART: begin
        scl_oe_d = scl_low;
        sda_oe_d = (phase == Q2) || (phase == Q3);
        if (last_q3) begin
          bit_d   = 3'd7;
          state_d = WR_BIT;
        end
      end
      RD_BIT: begin
        scl_oe_d = scl_low;
        if (q_end && (phase == Q2)) sr_d = {sr_q[6:0], sda_s};
        if (last_q3) begin
          if (bit_q == 3'd0) state_d = RD_ACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      RD_ACK: begin
        scl_oe_d = scl_low;
        if (last_q3) state_d = STOP;
      end
      STOP: begin
        // Second pass through Q0/Q1 is the bus-free tail with both lines released.
        if (!tail_q) begin
          scl_oe_d = (phase == Q0);
          sda_oe_d = (phase != Q3);
          if (last_q3) tail_d = 1'b1;
        end else if (q_end && (phase == Q1)) begin
          if (rw_q && (err_q == I2C_OK)) rdata_d = sr_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      byte_q   <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
      ack_q    <= 1'b0;
      tail_q   <= 1'b0;
      err_q    <= I2C_OK;
      rdata_q  <= '0;
      rw_q     <= 1'b0;
      dev_q    <= '0;
      reg_q    <= '0;
      wdata_q  <= '0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
      ack_q    <= ack_d;
      tail_q   <= tail_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rw_q     <= rw_d;
      dev_q    <= dev_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master against a behavioural I2C slave with a small
// register file (address 0x50) on a pulled-up open-drain bus.
module tb_i2c_master;

  localparam int QC = 8;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_dev_addr;
  logic [7:0] cmd_reg_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       busy;
  logic       scl_oe;
  logic       sda_oe;
  logic       scl_bus;
  logic       sda_bus;

  i2c_master #(
    .QUARTER_CNT(QC),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rw      (cmd_rw),
    .cmd_dev_addr(cmd_dev_addr),
    .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .scl_i       (scl_bus),
    .scl_oe      (scl_oe),
    .sda_i       (sda_bus),
    .sda_oe      (sda_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural slave + register file ----------------
  typedef enum int {S_IDLE, S_ADDR, S_REG, S_WDATA, S_RDATA} smode_e;

  smode_e     s_mode = S_IDLE;
  smode_e     s_next = S_IDLE;
  int         s_cnt = 0;
  logic [7:0] s_sh = '0;
  logic       s_ack = 1'b0;
  logic [7:0] s_ptr = '0;
  logic [7:0] s_tx = '0;
  logic       s_init = 1'b0;
  logic       sl_sda_low = 1'b0;
  int         str_cnt = 0;
  logic       stretch_done = 1'b0;
  int         stop_cnt = 0;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  logic [7:0] regs [256];
  logic [7:0] sw_in;
  logic       stretch_en;

  assign scl_bus = !(scl_oe || (str_cnt != 0));
  assign sda_bus = !(sda_oe || sl_sda_low);

  always @(negedge clk) begin
    p_scl <= scl_bus;
    p_sda <= sda_bus;
    if (str_cnt != 0) str_cnt <= str_cnt - 1;
    if (!s_init) begin
      for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
      regs[8'h00] <= 8'hA7;
      regs[8'h01] <= 8'h01;
      regs[8'h10] <= 8'h15;
      s_init <= 1'b1;
    end else if (p_scl && scl_bus && p_sda && !sda_bus) begin
      s_mode     <= S_ADDR;
      s_cnt      <= 0;
      s_ack      <= 1'b0;
      sl_sda_low <= 1'b0;
    end else if (p_scl && scl_bus && !p_sda && sda_bus) begin
      s_mode     <= S_IDLE;
      s_ack      <= 1'b0;
      sl_sda_low <= 1'b0;
      stop_cnt   <= stop_cnt + 1;
    end else if (!p_scl && scl_bus) begin
      if (!s_ack && (s_mode == S_ADDR || s_mode == S_REG || s_mode == S_WDATA)) begin
        s_sh  <= {s_sh[6:0], sda_bus};
        s_cnt <= s_cnt + 1;
      end
    end else if (p_scl && !scl_bus) begin
      if (stretch_en && !stretch_done && s_mode == S_REG && !s_ack && s_cnt == 4) begin
        str_cnt      <= 1000;
        stretch_done <= 1'b1;
      end
      if (s_ack) begin
        s_ack  <= 1'b0;
        s_mode <= s_next;
        s_cnt  <= 0;
        sl_sda_low <= (s_next == S_RDATA) ? !s_tx[7] : 1'b0;
      end else if ((s_mode == S_ADDR || s_mode == S_REG || s_mode == S_WDATA) && s_cnt == 8) begin
        case (s_mode)
          S_ADDR: begin
            if (s_sh[7:1] == 7'h50) begin
              s_ack      <= 1'b1;
              sl_sda_low <= 1'b1;
              s_next     <= s_sh[0] ? S_RDATA : S_REG;
              s_tx       <= (s_ptr == 8'h22) ? sw_in : regs[s_ptr];
            end else begin
              s_mode <= S_IDLE;
            end
          end
          S_REG: begin
            s_ack      <= 1'b1;
            sl_sda_low <= 1'b1;
            s_ptr      <= s_sh;
            s_next     <= S_WDATA;
          end
          default: begin
            s_ack       <= 1'b1;
            sl_sda_low  <= 1'b1;
            regs[s_ptr] <= s_sh;
            s_ptr       <= s_ptr + 8'd1;
            s_next      <= S_WDATA;
          end
        endcase
      end else if (s_mode == S_RDATA) begin
        if (s_cnt < 7) begin
          sl_sda_low <= !s_tx[3'(6 - s_cnt)];
          s_cnt      <= s_cnt + 1;
        end else begin
          sl_sda_low <= 1'b0;
          s_mode     <= S_IDLE;
        end
      end
    end
  end

  // Shortest SCL high period seen while the master is busy.
  logic mon_en;
  int   hi_run = 0;
  int   min_hi = 1000000;

  always @(negedge clk) begin
    if (!mon_en) begin
      hi_run <= 0;
      min_hi <= 1000000;
    end else if (scl_bus) begin
      hi_run <= hi_run + 1;
    end else begin
      if (hi_run != 0 && busy && hi_run < min_hi) min_hi <= hi_run;
      hi_run <= 0;
    end
  end

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                        input logic [7:0] wd, input bit hold,
                        output logic [1:0] err, output logic [7:0] rd, output int cyc);
    bit got;
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_rw       = rw;
    cmd_dev_addr = dev;
    cmd_reg_addr = ra;
    cmd_wdata    = wd;
    @(posedge clk);
    #1;
    chk("ready_drop", cmd_ready, 1'b0);
    chk("busy_set", busy, 1'b1);
    if (hold) begin
      cmd_dev_addr = 7'h51;
      cmd_reg_addr = 8'h01;
      repeat (5) @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) got = 1'b1;
    end
    chk("rsp_seen", got, 1'b1);
    err = rsp_err;
    rd  = rsp_rdata;
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid, 1'b0);
    chk("ready_after_rsp", cmd_ready, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  logic [1:0] err;
  logic [7:0] rd;
  int         cyc;
  int         stops0;

  initial begin
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_rw       = 1'b0;
    cmd_dev_addr = '0;
    cmd_reg_addr = '0;
    cmd_wdata    = '0;
    sw_in        = 8'h00;
    stretch_en   = 1'b0;
    mon_en       = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_scl_oe", scl_oe, 1'b0);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_rsp_err", rsp_err, 2'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    do_cmd(1'b0, 7'h50, 8'h05, 8'h55, 1'b0, err, rd, cyc);
    chk("wr05_55_err", err, 2'd0);
    do_cmd(1'b1, 7'h50, 8'h05, 8'h00, 1'b0, err, rd, cyc);
    chk("rd05_err", err, 2'd0);
    chk("rd05_55", rd, 8'h55);
    do_cmd(1'b0, 7'h50, 8'h05, 8'hAA, 1'b0, err, rd, cyc);
    chk("wr05_AA_err", err, 2'd0);
    do_cmd(1'b1, 7'h50, 8'h05, 8'h00, 1'b0, err, rd, cyc);
    chk("rd05_AA", rd, 8'hAA);

    do_cmd(1'b1, 7'h50, 8'h00, 8'h00, 1'b0, err, rd, cyc);
    chk("rd00_err", err, 2'd0);
    chk("rd00_A7", rd, 8'hA7);
    do_cmd(1'b1, 7'h50, 8'h01, 8'h00, 1'b0, err, rd, cyc);
    chk("rd01_01", rd, 8'h01);

    do_cmd(1'b0, 7'h50, 8'h20, 8'hF0, 1'b0, err, rd, cyc);
    chk("wr20_err", err, 2'd0);
    chk("led_out_F0", regs[8'h20], 8'hF0);
    sw_in = 8'h3C;
    do_cmd(1'b1, 7'h50, 8'h22, 8'h00, 1'b0, err, rd, cyc);
    chk("rd22_sw_in", rd, 8'h3C);

    // cmd_valid held while busy with different fields: must be ignored
    do_cmd(1'b1, 7'h50, 8'h10, 8'h00, 1'b1, err, rd, cyc);
    chk("rd10_hold_err", err, 2'd0);
    chk("rd10_15", rd, 8'h15);

    stops0 = stop_cnt;
    do_cmd(1'b1, 7'h51, 8'h00, 8'h00, 1'b0, err, rd, cyc);
    chk("nack_addr_err", err, 2'd1);
    chk("nack_rdata_kept", rd, 8'h15);
    chk("nack_stop_seen", stop_cnt - stops0, 1);
    chk("nack_scl_oe_rel", scl_oe, 1'b0);
    chk("nack_sda_oe_rel", sda_oe, 1'b0);
    chk("nack_bus_high", {scl_bus, sda_bus}, 2'b11);

    mon_en     = 1'b1;
    stretch_en = 1'b1;
    do_cmd(1'b0, 7'h50, 8'h06, 8'h3A, 1'b0, err, rd, cyc);
    chk("stretch_err", err, 2'd0);
    chk("stretch_happened", stretch_done, 1'b1);
    chk("stretch_long_txn", cyc > 1500, 1'b1);
    chk("scl_high_min", min_hi >= QC, 1'b1);
    mon_en = 1'b0;
    do_cmd(1'b1, 7'h50, 8'h06, 8'h00, 1'b0, err, rd, cyc);
    chk("rd06_3A", rd, 8'h3A);

    // Reset during the data byte while the master is pulling both lines low.
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_rw       = 1'b0;
    cmd_dev_addr = 7'h50;
    cmd_reg_addr = 8'h07;
    cmd_wdata    = 8'h66;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cyc = 0;
    while (!(s_mode == S_WDATA && scl_oe && sda_oe) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    chk("reach_wdata_low", cyc < 20000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_scl_oe", scl_oe, 1'b0);
    chk("arst_sda_oe", sda_oe, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ready", cmd_ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    do_cmd(1'b1, 7'h50, 8'h00, 8'h00, 1'b0, err, rd, cyc);
    chk("post_rst_err", err, 2'd0);
    chk("post_rst_A7", rd, 8'hA7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
